// File: rtl/aud_pkg.sv
// Shared constants for the audio DAC feeder: sample width, FIFO sizing and
// which LRC transition marks the start of a frame.
package aud_pkg;
  localparam int AUD_DW = 32;
  localparam int AUD_AW = 8;
  localparam int AUD_LOW_WM = 64;
  localparam bit LRC_FRAME_FALL = 1'b1;

  function automatic logic frame_edge(input logic prev_lvl, input logic cur_lvl);
    if (LRC_FRAME_FALL) begin
      frame_edge = prev_lvl & ~cur_lvl;
    end else begin
      frame_edge = ~prev_lvl & cur_lvl;
    end
  endfunction
endpackage

// File: rtl/aud_sync_fifo.sv
// Single-clock sample FIFO with a registered read port.
// The status outputs are registered from the next-state pointers.
module aud_sync_fifo
  import aud_pkg::*;
#(
  parameter int DW     = AUD_DW,
  parameter int AW     = AUD_AW,
  parameter int LOW_WM = AUD_LOW_WM
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic [DW-1:0] wr_data,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic          pop,
  input  logic          rd_clr,
  output logic [DW-1:0] rd_data,
  output logic          empty,
  output logic [AW:0]   fill_level,
  output logic          low_wm
);
  localparam logic [AW:0] PTR_ONE    = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0] LOW_WM_LVL = LOW_WM[AW:0];

  logic [DW-1:0] mem [0:2**AW-1];
  logic [AW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, level_q, level_d;
  logic          wr_ready_q, wr_ready_d, low_wm_q, low_wm_d, empty_q, empty_d;
  logic [DW-1:0] rd_data_q, rd_data_d;
  logic          wr_en, rd_en;

  // Pointer update and next-state status
  always_comb begin
    wr_en    = wr_valid & wr_ready_q & ~flush;
    rd_en    = pop & ~empty_q & ~flush;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (wr_en) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (rd_en) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
    end
    level_d    = wr_ptr_d - rd_ptr_d;
    empty_d    = (wr_ptr_d == rd_ptr_d);
    wr_ready_d = ~((wr_ptr_d[AW] != rd_ptr_d[AW]) &&
                   (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]));
    low_wm_d   = (level_d <= LOW_WM_LVL);
  end

  // Read data register; cleared on flush or when the frame is muted
  always_comb begin
    rd_data_d = rd_data_q;
    if (flush || rd_clr) begin
      rd_data_d = '0;
    end else if (rd_en) begin
      rd_data_d = mem[rd_ptr_q[AW-1:0]];
    end else begin
      rd_data_d = rd_data_q;
    end
  end

  // Sample storage, left unreset so it maps onto block RAM
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_q[AW-1:0]] <= wr_data;
    end
  end

  // State registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      empty_q    <= 1'b1;
      wr_ready_q <= 1'b1;
      low_wm_q   <= 1'b1;
      rd_data_q  <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      empty_q    <= empty_d;
      wr_ready_q <= wr_ready_d;
      low_wm_q   <= low_wm_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign wr_ready   = wr_ready_q;
  assign rd_data    = rd_data_q;
  assign empty      = empty_q;
  assign fill_level = level_q;
  assign low_wm     = low_wm_q;
endmodule

// File: rtl/aud_dac_feeder.sv
// Feeds one buffered stereo sample per WM8978 frame to the codec controller.
// Frame timing comes from aud_lrc, synchronised into clk.
module aud_dac_feeder
  import aud_pkg::*;
#(
  parameter int DW     = AUD_DW,
  parameter int AW     = AUD_AW,
  parameter int LOW_WM = AUD_LOW_WM
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          aud_lrc,
  input  logic          enable,
  input  logic          flush,
  input  logic [DW-1:0] wr_data,
  input  logic          wr_valid,
  output logic          wr_ready,
  output logic [DW-1:0] dac_data,
  output logic [AW:0]   fill_level,
  output logic          low_wm,
  output logic          underrun,
  output logic [15:0]   underrun_cnt
);
  logic        lrc_s1_q, lrc_s2_q, lrc_d_q;
  logic        tick_q, tick_d;
  logic        underrun_q, underrun_d;
  logic [15:0] underrun_cnt_q, underrun_cnt_d;
  logic        pop, mute, fifo_empty;

  aud_sync_fifo #(.DW(DW), .AW(AW), .LOW_WM(LOW_WM)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .wr_data    (wr_data),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .pop        (pop),
    .rd_clr     (mute),
    .rd_data    (dac_data),
    .empty      (fifo_empty),
    .fill_level (fill_level),
    .low_wm     (low_wm)
  );

  // Frame tick decode: pop, mute, or record an underrun; flush overrides all
  always_comb begin
    tick_d         = frame_edge(lrc_d_q, lrc_s2_q);
    pop            = 1'b0;
    mute           = 1'b0;
    underrun_d     = 1'b0;
    underrun_cnt_d = underrun_cnt_q;
    if (tick_q && !flush) begin
      if (!enable) begin
        mute = 1'b1;
      end else if (fifo_empty) begin
        mute       = 1'b1;
        underrun_d = 1'b1;
        if (underrun_cnt_q != 16'hFFFF) begin
          underrun_cnt_d = underrun_cnt_q + 16'd1;
        end else begin
          underrun_cnt_d = underrun_cnt_q;
        end
      end else begin
        pop = 1'b1;
      end
    end else begin
      pop = 1'b0;
    end
  end

  // LRC synchroniser, edge history and tick/underrun registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lrc_s1_q       <= 1'b0;
      lrc_s2_q       <= 1'b0;
      lrc_d_q        <= 1'b0;
      tick_q         <= 1'b0;
      underrun_q     <= 1'b0;
      underrun_cnt_q <= 16'd0;
    end else begin
      lrc_s1_q       <= aud_lrc;
      lrc_s2_q       <= lrc_s1_q;
      lrc_d_q        <= lrc_s2_q;
      tick_q         <= tick_d;
      underrun_q     <= underrun_d;
      underrun_cnt_q <= underrun_cnt_d;
    end
  end

  assign underrun     = underrun_q;
  assign underrun_cnt = underrun_cnt_q;
endmodule

// File: tb/tb_aud_dac_feeder.sv
// Directed bench for aud_dac_feeder: frame playback, underrun, full FIFO,
// mute, watermark, flush and asynchronous reset.
module tb_aud_dac_feeder;
  logic        clk, rst, aud_lrc, enable, flush, wr_valid, wr_ready;
  logic [31:0] wr_data, dac_data;
  logic [8:0]  fill_level;
  logic        low_wm, underrun;
  logic [15:0] underrun_cnt;
  int total = 0;
  int bad = 0;
  int und_seen = 0;
  int und_base;

  aud_dac_feeder dut (
    .clk(clk), .rst(rst), .aud_lrc(aud_lrc), .enable(enable), .flush(flush),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .dac_data(dac_data), .fill_level(fill_level), .low_wm(low_wm),
    .underrun(underrun), .underrun_cnt(underrun_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (underrun === 1'b1) und_seen++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic write_n(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      wr_data = base + 32'(i); wr_valid = 1'b1;
      @(negedge clk);
    end
    wr_valid = 1'b0;
  endtask

  task automatic lrc_frame();
    aud_lrc = 1'b1; repeat (6) @(negedge clk);
    aud_lrc = 1'b0; repeat (8) @(negedge clk);
  endtask

  // Leaves the caller at the negedge where the registered tick is high
  task automatic lrc_to_tick();
    aud_lrc = 1'b1; repeat (6) @(negedge clk);
    aud_lrc = 1'b0; repeat (3) @(negedge clk);
  endtask

  task automatic frame_measure(input logic [31:0] exp, input string tag);
    int lat;
    aud_lrc = 1'b1; repeat (6) @(negedge clk);
    aud_lrc = 1'b0; lat = 0;
    do begin @(negedge clk); lat++; end while (dac_data !== exp && lat < 8);
    chk({tag, "_data"}, dac_data, exp);
    chk({tag, "_lat"}, 32'(lat <= 5), 32'd1);
    repeat (4) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; aud_lrc = 1'b0; enable = 1'b0; flush = 1'b0;
    wr_valid = 1'b0; wr_data = 32'd0;
    repeat (3) @(negedge clk);
    chk("rst_dac", dac_data, 32'd0);
    chk("rst_fill", 32'(fill_level), 32'd0);
    chk("rst_ready", 32'(wr_ready), 32'd1);
    chk("rst_lowwm", 32'(low_wm), 32'd1);
    chk("rst_und", 32'(underrun), 32'd0);
    chk("rst_cnt", 32'(underrun_cnt), 32'd0);
    rst = 1'b0; enable = 1'b1;
    @(negedge clk);

    // 1: four samples out in order
    write_n(32'h0001_0002, 1); write_n(32'h0002_0003, 1);
    write_n(32'h0003_0004, 1); write_n(32'h0004_0005, 1);
    chk("t1_fill4", 32'(fill_level), 32'd4);
    frame_measure(32'h0001_0002, "t1_f1"); chk("t1_fill3", 32'(fill_level), 32'd3);
    frame_measure(32'h0002_0003, "t1_f2"); chk("t1_fill2", 32'(fill_level), 32'd2);
    frame_measure(32'h0003_0004, "t1_f3"); chk("t1_fill1", 32'(fill_level), 32'd1);
    frame_measure(32'h0004_0005, "t1_f4"); chk("t1_fill0", 32'(fill_level), 32'd0);

    // 2: underrun and saturation
    und_base = und_seen;
    lrc_frame();
    chk("t2_dac0", dac_data, 32'd0);
    chk("t2_pulses", 32'(und_seen - und_base), 32'd1);
    chk("t2_cnt1", 32'(underrun_cnt), 32'd1);
    force dut.underrun_cnt_q = 16'hFFFE;
    @(negedge clk);
    release dut.underrun_cnt_q;
    lrc_frame();
    chk("t2_cnt_max", 32'(underrun_cnt), 32'h0000_FFFF);
    lrc_frame();
    chk("t2_cnt_sat", 32'(underrun_cnt), 32'h0000_FFFF);

    // 3: full FIFO
    write_n(32'hA000_0000, 256);
    chk("t3_ready0", 32'(wr_ready), 32'd0);
    chk("t3_fill256", 32'(fill_level), 32'd256);
    wr_data = 32'hDEAD_BEEF; wr_valid = 1'b1; @(negedge clk); wr_valid = 1'b0;
    chk("t3_ignored", 32'(fill_level), 32'd256);
    lrc_to_tick();
    @(negedge clk);
    chk("t3_fill255", 32'(fill_level), 32'd255);
    chk("t3_ready1", 32'(wr_ready), 32'd1);
    chk("t3_dac", dac_data, 32'hA000_0000);
    flush = 1'b1; @(negedge clk); flush = 1'b0;
    chk("t3_flushed", 32'(fill_level), 32'd0);

    // 4: mute
    write_n(32'hB000_0000, 11);
    lrc_frame();
    chk("t4_first", dac_data, 32'hB000_0000);
    enable = 1'b0; und_base = und_seen;
    lrc_frame(); lrc_frame(); lrc_frame();
    chk("t4_mute_dac", dac_data, 32'd0);
    chk("t4_mute_fill", 32'(fill_level), 32'd10);
    chk("t4_mute_und", 32'(und_seen - und_base), 32'd0);
    enable = 1'b1;
    lrc_frame();
    chk("t4_resume", dac_data, 32'hB000_0001);
    chk("t4_fill9", 32'(fill_level), 32'd9);

    // 5: write coinciding with a pop around the watermark
    write_n(32'hC000_0000, 56);
    chk("t5_fill65", 32'(fill_level), 32'd65);
    lrc_to_tick();
    wr_data = 32'hC000_00FF; wr_valid = 1'b1; @(negedge clk); wr_valid = 1'b0;
    chk("t5_same_fill", 32'(fill_level), 32'd65);
    chk("t5_lowwm0", 32'(low_wm), 32'd0);
    chk("t5_pop_dac", dac_data, 32'hB000_0002);
    lrc_frame();
    chk("t5_fill64", 32'(fill_level), 32'd64);
    chk("t5_lowwm1", 32'(low_wm), 32'd1);

    // 6: flush beats a write and a pop, then async reset mid-frame
    flush = 1'b1; @(negedge clk); flush = 1'b0;
    write_n(32'hD000_0000, 20);
    chk("t6_fill20", 32'(fill_level), 32'd20);
    und_base = und_seen;
    lrc_to_tick();
    flush = 1'b1; wr_data = 32'hD000_00FF; wr_valid = 1'b1;
    @(negedge clk);
    flush = 1'b0; wr_valid = 1'b0;
    chk("t6_fill0", 32'(fill_level), 32'd0);
    chk("t6_dac0", dac_data, 32'd0);
    chk("t6_cnt", 32'(underrun_cnt), 32'h0000_FFFF);
    chk("t6_und", 32'(und_seen - und_base), 32'd0);
    write_n(32'hE000_0000, 2);
    lrc_frame();
    chk("t6_pre_rst", dac_data, 32'hE000_0000);
    aud_lrc = 1'b1; repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_dac", dac_data, 32'd0);
    chk("t6_rst_fill", 32'(fill_level), 32'd0);
    chk("t6_rst_ready", 32'(wr_ready), 32'd1);
    chk("t6_rst_lowwm", 32'(low_wm), 32'd1);
    chk("t6_rst_cnt", 32'(underrun_cnt), 32'd0);
    aud_lrc = 1'b0;
    @(negedge clk); rst = 1'b0;
    write_n(32'hF000_0001, 1);
    repeat (10) @(negedge clk);
    chk("t6_no_tick", 32'(fill_level), 32'd1);
    lrc_frame();
    chk("t6_post_rst", dac_data, 32'hF000_0001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
